// File: rtl/fbs_restore_unpacker_if.sv
// Restore-side handshake bundle between control, the fbs restore port and the
// f-register file write port. The unpacker uses the slave modport.
interface fbs_restore_unpacker_if #(
  parameter int WORD_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
);
  logic                         restoreReq;
  logic [15:0]                  fbsCount;
  logic                         fbsRestore;
  logic                         fbsRestoreOut;
  logic [WORD_W*NUM_REGS-1:0]   fbsDataOut;
  logic                         regWrite;
  logic [ADDR_W-1:0]            regAddr;
  logic [WORD_W-1:0]            regData;
  logic                         busy;
  logic                         done;
  logic                         error;

  modport master (
    output restoreReq, fbsCount, fbsRestoreOut, fbsDataOut,
    input  fbsRestore, regWrite, regAddr, regData, busy, done, error
  );

  modport slave (
    input  restoreReq, fbsCount, fbsRestoreOut, fbsDataOut,
    output fbsRestore, regWrite, regAddr, regData, busy, done, error
  );
endinterface

// File: rtl/fbs_restore_unpacker.sv
// Pops one snapshot from fbs and writes it back into the f-register file, one
// register per cycle. Optional WAIT timeout: define FBS_RESTORE_TIMEOUT_EN.
module fbs_restore_unpacker #(
  parameter int WORD_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int TIMEOUT  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  fbs_restore_unpacker_if.slave ifc
);
  localparam int IMG_W = WORD_W * NUM_REGS;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IMG_W-1:0]  shadow_q;
  logic [ADDR_W-1:0] idx_q;
  logic              error_q, error_d;
  logic              load;

`ifdef FBS_RESTORE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] tmo_q;
  logic            tmo_hit;

  // Counter is zero on the first WAIT cycle, so the last allowed cycle is TIMEOUT-1.
  assign tmo_hit = (tmo_q == TO_LAST);
`endif

  always_comb begin
    state_d = state_q;
    error_d = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ifc.restoreReq) begin
          if (ifc.fbsCount != 16'd0) state_d = S_REQ;
          else                       error_d = 1'b1;
        end
      end
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (ifc.fbsRestoreOut) begin
          state_d = S_WRITE;
          load    = 1'b1;
        end
`ifdef FBS_RESTORE_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end
`endif
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      error_q  <= 1'b0;
      idx_q    <= '0;
      shadow_q <= '0;
`ifdef FBS_RESTORE_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      if (load) begin
        shadow_q <= ifc.fbsDataOut;
        idx_q    <= '0;
      end else if (state_q == S_WRITE) begin
        idx_q <= idx_q + ADDR_W'(1);
      end
`ifdef FBS_RESTORE_TIMEOUT_EN
      if (state_q == S_WAIT) tmo_q <= tmo_q + TO_W'(1);
      else                   tmo_q <= '0;
`endif
    end
  end

  // Write port is quiet (all zero) outside WRITE.
  assign ifc.fbsRestore = (state_q == S_REQ);
  assign ifc.busy       = (state_q != S_IDLE);
  assign ifc.regWrite   = (state_q == S_WRITE);
  assign ifc.regAddr    = (state_q == S_WRITE) ? idx_q : '0;
  assign ifc.regData    = (state_q == S_WRITE) ? shadow_q[idx_q*WORD_W +: WORD_W] : '0;
  assign ifc.done       = (state_q == S_DONE);
  assign ifc.error      = error_q;
endmodule

// File: tb/tb_fbs_restore_unpacker.sv
// Randomized and directed bench for fbs_restore_unpacker, checked every cycle
// against an edge-arithmetic model of the restore timeline.
module tb_fbs_restore_unpacker;
  localparam int WORD_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int TIMEOUT  = 8;
  localparam int IMG_W    = WORD_W * NUM_REGS;
  localparam int NEVER    = 32'h3fff_ffff;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fbs_restore_unpacker_if #(.WORD_W(WORD_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) ifc ();

  fbs_restore_unpacker #(
    .WORD_W(WORD_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ifc  (ifc.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction is described by its accept edge a_e and data edge d_e;
  // every output follows from the current edge number by plain arithmetic.
  int               edge_n = 0;
  int               a_e = -1, d_e = -1, free_e = NEVER;
  logic [IMG_W-1:0] img_m;
  bit               started = 0;
  logic             x_frs, x_busy, x_wr, x_done, x_err;
  logic [15:0]      x_addr, x_data;

  always @(posedge clk) begin
    int e;
    edge_n++;
    e     = edge_n;
    x_err = 1'b0;
    if (reset) begin
      a_e = -1; d_e = -1; free_e = e + 1;
    end else if (e >= free_e && ifc.restoreReq) begin
      if (ifc.fbsCount != 0) begin
        a_e = e; d_e = -1; free_e = NEVER;
      end else begin
        x_err = 1'b1;
      end
    end else if (a_e >= 0 && d_e < 0 && e >= a_e + 2) begin
      if (ifc.fbsRestoreOut) begin
        d_e = e; img_m = ifc.fbsDataOut; free_e = e + NUM_REGS + 2;
      end
`ifdef FBS_RESTORE_TIMEOUT_EN
      else if (e == a_e + 1 + TIMEOUT) begin
        x_err = 1'b1; a_e = -1; free_e = e + 1;
      end
`endif
    end
    x_frs  = (a_e >= 0) && (e == a_e);
    x_busy = (a_e >= 0) && (e >= a_e) && (d_e < 0 || e <= d_e + NUM_REGS);
    x_wr   = (d_e >= 0) && (e <= d_e + NUM_REGS - 1);
    x_done = (d_e >= 0) && (e == d_e + NUM_REGS);
    x_addr = x_wr ? 16'(e - d_e) : 16'd0;
    x_data = x_wr ? img_m[(e - d_e)*WORD_W +: WORD_W] : 16'd0;
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("fbsRestore", 32'(ifc.fbsRestore), 32'(x_frs));
      chk("busy",       32'(ifc.busy),       32'(x_busy));
      chk("regWrite",   32'(ifc.regWrite),   32'(x_wr));
      chk("regAddr",    32'(ifc.regAddr),    32'(x_addr));
      chk("regData",    32'(ifc.regData),    32'(x_data));
      chk("done",       32'(ifc.done),       32'(x_done));
      chk("error",      32'(ifc.error),      32'(x_err));
    end
  end

  int          pops = 0, dones = 0, errs = 0;
  logic [15:0] wr_q[$];

  always @(negedge clk) begin
    if (ifc.fbsRestore) pops++;
    if (ifc.done)       dones++;
    if (ifc.error)      errs++;
    if (ifc.regWrite)   wr_q.push_back(ifc.regData);
  end

  task automatic clear_logs();
    pops = 0; dones = 0; errs = 0; wr_q.delete();
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_req();
    ifc.restoreReq = 1'b1;
    tick();
    ifc.restoreReq = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    int k = 0;
    while (!ifc.done && k < lim) begin tick(); k++; end
    chk(nm, 32'(ifc.done), 32'd1);
  endtask

  task automatic wait_addr(input string nm, input logic [ADDR_W-1:0] a, input int lim);
    int k = 0;
    while (!(ifc.regWrite && ifc.regAddr == a) && k < lim) begin tick(); k++; end
    chk(nm, 32'(ifc.regWrite && ifc.regAddr == a), 32'd1);
  endtask

  logic [IMG_W-1:0] img_a;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n6;
    for (int i = 0; i < NUM_REGS; i++) img_a[i*WORD_W +: WORD_W] = 16'hA000 + 16'(i);
    ifc.restoreReq    = 1'b0;
    ifc.fbsCount      = 16'd0;
    ifc.fbsRestoreOut = 1'b0;
    ifc.fbsDataOut    = '0;
    reset = 1'b1;
    tick(3);
    chk("rst_busy",  32'(ifc.busy),     32'd0);
    chk("rst_write", 32'(ifc.regWrite), 32'd0);
    chk("rst_pop",   32'(ifc.fbsRestore), 32'd0);
    reset = 1'b0;
    tick(2);

    // Basic restore
    clear_logs();
    ifc.fbsCount = 16'd3; ifc.fbsDataOut = img_a; ifc.fbsRestoreOut = 1'b1;
    pulse_req();
    wait_done("basic_done", 60);
    tick(2);
    chk("basic_nwr",  32'(wr_q.size()), 32'd16);
    chk("basic_w0",   32'(wr_q[0]),  32'h0000A000);
    chk("basic_w9",   32'(wr_q[9]),  32'h0000A009);
    chk("basic_w15",  32'(wr_q[15]), 32'h0000A00F);
    chk("basic_pops", 32'(pops),  32'd1);
    chk("basic_done_cnt", 32'(dones), 32'd1);

    // Underflow
    clear_logs();
    ifc.fbsCount = 16'd0;
    pulse_req();
    tick(4);
    chk("uf_err",  32'(errs), 32'd1);
    chk("uf_pops", 32'(pops), 32'd0);
    chk("uf_nwr",  32'(wr_q.size()), 32'd0);

    // Request held high across restores: one accept every 20 edges
    clear_logs();
    ifc.fbsCount = 16'd2;
    ifc.restoreReq = 1'b1;
    tick(45);
    ifc.restoreReq = 1'b0;
    tick(25);
    chk("hold_pops",  32'(pops),  32'd3);
    chk("hold_dones", 32'(dones), 32'd3);
    chk("hold_nwr",   32'(wr_q.size()), 32'd48);

    // Source data changes during write-back
    clear_logs();
    ifc.fbsDataOut = img_a;
    pulse_req();
    wait_addr("chg_reach4", 4'd4, 40);
    ifc.fbsDataOut = '1;
    wait_done("chg_done", 40);
    tick(2);
    chk("chg_w4",  32'(wr_q[4]),  32'h0000A004);
    chk("chg_w15", 32'(wr_q[15]), 32'h0000A00F);

    // Reset in the middle of write-back, then a fresh restore
    clear_logs();
    ifc.fbsDataOut = img_a;
    pulse_req();
    wait_addr("rstw_reach5", 4'd5, 40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_write", 32'(ifc.regWrite), 32'd0);
    chk("rstw_busy",  32'(ifc.busy),     32'd0);
    n6 = wr_q.size();
    tick(20);
    chk("rstw_nwr", 32'(wr_q.size()), 32'(n6));
    pulse_req();
    wait_done("rstw_fresh_done", 60);
    tick(2);
    chk("rstw_total", 32'(wr_q.size()), 32'(n6 + 16));

    // No restore data ever arrives
    clear_logs();
    ifc.fbsRestoreOut = 1'b0;
    ifc.fbsCount = 16'd1;
    pulse_req();
`ifdef FBS_RESTORE_TIMEOUT_EN
    tick(15);
    chk("tmo_err",  32'(errs), 32'd1);
    chk("tmo_busy", 32'(ifc.busy), 32'd0);
`else
    tick(40);
    chk("hang_busy", 32'(ifc.busy), 32'd1);
    chk("hang_err",  32'(errs), 32'd0);
`endif
    chk("nodata_nwr", 32'(wr_q.size()), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      ifc.restoreReq    = ($urandom % 4) == 0;
      ifc.fbsCount      = (($urandom % 5) == 0) ? 16'd0 : 16'($urandom_range(1, 100));
      ifc.fbsRestoreOut = ($urandom % 3) == 0;
      for (int w = 0; w < IMG_W / 32; w++) ifc.fbsDataOut[w*32 +: 32] = $urandom;
      reset = ($urandom % 150) == 0;
      tick();
    end
    reset = 1'b0;
    ifc.restoreReq = 1'b0;
    tick(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
